// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to packed-BCD converter.
// Converts one input bit per clock using add-3 then shift, so a conversion
// takes BIN_W clocks. bcd_out and ovf hold the last result between conversions.
// Optional feature macro: BIN_TO_BCD_OVF_EN. When it is defined, inputs above
// 10^DIGITS-1 saturate to all nines and raise ovf. When it is undefined, ovf
// is tied low and the low DIGITS decimal digits are reported.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_W  = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int unsigned SCR_W = 4 * DIGITS;
    localparam int unsigned CAT_W = SCR_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [BIN_W-1:0]   sh;
    logic [SCR_W-1:0]   scr;
    logic [CNT_W-1:0]   cnt;

    logic [SCR_W-1:0]   scr_adj;
    logic [CAT_W-1:0]   cat_step;
    logic [SCR_W-1:0]   scr_step;
    logic [BIN_W-1:0]   sh_step;
    logic               last;

    logic               load;
    logic               step;
    logic               busy_nxt;
    logic               done_nxt;
    logic [SCR_W-1:0]   bcd_nxt;

`ifdef BIN_TO_BCD_OVF_EN
    // Largest value representable in DIGITS decimal digits.
    function automatic logic [63:0] max_dec(input int unsigned d);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_dec(DIGITS);

    logic               ovf_pending;
    logic               ovf_nxt;
`endif

    // One double-dabble step: add 3 to every digit >= 5, then shift left.
    always_comb begin
        scr_adj = scr;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scr[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
            end
        end
        cat_step = {scr_adj, sh} << 1;
    end

    assign scr_step = cat_step[CAT_W-1 -: SCR_W];
    assign sh_step  = cat_step[BIN_W-1:0];
    assign last     = (cnt == CNT_W'(BIN_W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath-control decode; outputs are registered below.
    always_comb begin
        load     = 1'b0;
        step     = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        bcd_nxt  = bcd_out;
`ifdef BIN_TO_BCD_OVF_EN
        ovf_nxt  = ovf;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    done_nxt = 1'b1;
`ifdef BIN_TO_BCD_OVF_EN
                    if (ovf_pending) begin
                        bcd_nxt = {DIGITS{4'h9}};
                        ovf_nxt = 1'b1;
                    end else begin
                        bcd_nxt = scr_step;
                        ovf_nxt = 1'b0;
                    end
`else
                    bcd_nxt = scr_step;
`endif
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    // Registered outputs; bcd_out only moves at the done edge or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
        end else begin
            busy    <= busy_nxt;
            done    <= done_nxt;
            bcd_out <= bcd_nxt;
        end
    end

`ifdef BIN_TO_BCD_OVF_EN
    // Overflow flag, updated together with bcd_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_nxt;
        end
    end

    // Range check of the captured input, applied when the result is published.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_pending <= 1'b0;
        end else if (load) begin
            ovf_pending <= (64'(bin_in) > MAX_VAL);
        end
    end
`else
    assign ovf = 1'b0;
`endif

    // Conversion datapath: capture on accept, one add-3/shift per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            scr <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= bin_in;
            scr <= '0;
            cnt <= '0;
        end else if (step) begin
            sh  <= sh_step;
            scr <= scr_step;
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three instances (10b/4 digits, 14b/4 digits,
// 1b/1 digit) checked against a division-based decimal reference model.
module tb_bin_to_bcd_seq;

`ifdef BIN_TO_BCD_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start0 = 1'b0;
    logic [9:0]  bin0 = '0;
    logic        busy0, done0, ovf0;
    logic [15:0] bcd0;

    logic        start1 = 1'b0;
    logic [13:0] bin1 = '0;
    logic        busy1, done1, ovf1;
    logic [15:0] bcd1;

    logic        start2 = 1'b0;
    logic [0:0]  bin2 = '0;
    logic        busy2, done2, ovf2;
    logic [3:0]  bcd2;

    int n_cmp  = 0;
    int n_fail = 0;

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .bin_in(bin0),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .ovf(ovf0));

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bin_in(bin1),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .ovf(ovf1));

    bin_to_bcd_seq #(.BIN_W(1), .DIGITS(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin_in(bin2),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2));

    always #5 clk = ~clk;

    // Reference: decimal digits by plain division, saturated when enabled.
    function automatic longint unsigned max_dec(input int d);
        longint unsigned p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p - 1;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int d);
        return OVF_EN && (v > max_dec(d));
    endfunction

    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
        logic [63:0]     r = '0;
        longint unsigned x = v;
        if (ref_ovf(v, d)) begin
            for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
        end else begin
            for (int i = 0; i < d; i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [63:0] bcd_of(input int sel);
        case (sel)
            0:       return 64'(bcd0);
            1:       return 64'(bcd1);
            default: return 64'(bcd2);
        endcase
    endfunction

    function automatic logic ovf_of(input int sel);
        case (sel)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    // Start one conversion on instance sel and check latency, result and ovf.
    task automatic do_conv(input int sel, input longint unsigned v);
        int lat = 0;
        int bw;
        int dg;
        logic got = 1'b0;
        case (sel)
            0:       begin start0 = 1'b1; bin0 = 10'(v); bw = 10; dg = 4; end
            1:       begin start1 = 1'b1; bin1 = 14'(v); bw = 14; dg = 4; end
            default: begin start2 = 1'b1; bin2 = 1'(v);  bw = 1;  dg = 1; end
        endcase
        tick();
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        bin0 = 10'($urandom); bin1 = 14'($urandom); bin2 = 1'($urandom);
        while (!got && lat < 40) begin
            tick();
            lat++;
            got = done_of(sel);
        end
        chk($sformatf("latency[%0d] v=%0d", sel, v), 64'(lat), 64'(bw));
        chk($sformatf("bcd[%0d] v=%0d", sel, v), bcd_of(sel), ref_bcd(v, dg));
        chk($sformatf("ovf[%0d] v=%0d", sel, v), 64'(ovf_of(sel)), 64'(ref_ovf(v, dg)));
    endtask

    initial begin
        logic        seen;
        int          lat;
        longint unsigned a;

        // Reset held two clocks, then idle for 20 clocks.
        rst = 1'b1;
        tick();
        tick();
        chk("rst busy", 64'(busy0), 64'd0);
        chk("rst done", 64'(done0), 64'd0);
        chk("rst bcd",  64'(bcd0),  64'h0);
        chk("rst ovf",  64'(ovf0),  64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy0 !== 1'b0 || done0 !== 1'b0 || bcd0 !== 16'h0) seen = 1'b1;
        end
        chk("idle unchanged", 64'(seen), 64'd0);

        // 1023 with a prior result held for the whole conversion.
        do_conv(0, 567);
        start0 = 1'b1;
        bin0   = 10'd1023;
        tick();
        start0 = 1'b0;
        chk("accept busy", 64'(busy0), 64'd1);
        seen = 1'b0;
        for (int i = 1; i < 10; i++) begin
            tick();
            if (busy0 !== 1'b1 || done0 !== 1'b0 || bcd0 !== 16'h0567) seen = 1'b1;
        end
        chk("held during shift", 64'(seen), 64'd0);
        tick();
        chk("1023 done",  64'(done0), 64'd1);
        chk("1023 busy",  64'(busy0), 64'd0);
        chk("1023 bcd",   64'(bcd0),  64'h1023);
        tick();
        chk("done one cycle", 64'(done0), 64'd0);
        chk("bcd holds",      64'(bcd0),  64'h1023);

        // Back-to-back sweep, each start issued in the done cycle.
        for (int v = 0; v < 1024; v++) do_conv(0, longint'(v));

        // Start during conversion is ignored and not queued.
        a = longint'($urandom_range(1023));
        start0 = 1'b1;
        bin0   = 10'(a);
        tick();
        start0 = 1'b0;
        lat = 0;
        tick(); lat++;
        tick(); lat++;
        start0 = 1'b1;
        bin0   = 10'd7;
        tick(); lat++;
        start0 = 1'b0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            tick();
            lat++;
            seen = done0;
        end
        chk("ignored start latency", 64'(lat), 64'd10);
        chk("ignored start bcd", 64'(bcd0), ref_bcd(a, 4));
        tick();
        chk("not queued busy", 64'(busy0), 64'd0);

        // Reset mid-conversion aborts without a done pulse.
        start0 = 1'b1;
        bin0   = 10'd999;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 64'(busy0), 64'd0);
        chk("abort done", 64'(done0), 64'd0);
        chk("abort bcd",  64'(bcd0),  64'h0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done0 !== 1'b0 || busy0 !== 1'b0) seen = 1'b1;
        end
        chk("no done after abort", 64'(seen), 64'd0);

        // 14-bit instance: overflow handling and random values.
        do_conv(1, 12345);
        do_conv(1, 9999);
        do_conv(1, 0);
        do_conv(1, 16383);
        for (int i = 0; i < 40; i++) do_conv(1, longint'($urandom_range(16383)));

        // Single-bit, single-digit instance.
        do_conv(2, 1);
        do_conv(2, 0);
        do_conv(2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
